// File: rtl/monitor_gain_controller.sv
// Stereo monitor gain stage: per-pair gain multiply, floor shift, saturation and clip flag.
// Optional macro MONITOR_GAIN_RAMP_EN makes the applied gain slew toward the target by RAMP_STEP per pair.
module monitor_gain_controller #(
    parameter int DATA_WIDTH = 24,
    parameter int GAIN_WIDTH = 8,
    parameter int RAMP_STEP  = 1
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic [DATA_WIDTH-1:0] i_data_left,
    input  logic [DATA_WIDTH-1:0] i_data_right,
    input  logic                  i_data_valid,
    input  logic [GAIN_WIDTH-1:0] i_gain,
    input  logic                  i_mute,
    output logic [DATA_WIDTH-1:0] o_data_left,
    output logic [DATA_WIDTH-1:0] o_data_right,
    output logic                  o_data_valid,
    output logic                  o_clip,
    output logic [GAIN_WIDTH-1:0] o_gain_current
);

    // Handshake: i_data_valid is a one-cycle strobe with no ready; every pair presented
    // outside reset is accepted, and o_data_valid pulses once for it exactly two cycles later.

`ifdef MONITOR_GAIN_RAMP_EN
    localparam bit RAMP_EN = 1'b1;
`else
    localparam bit RAMP_EN = 1'b0;
`endif

    localparam int PW = DATA_WIDTH + GAIN_WIDTH + 1;
    localparam logic [GAIN_WIDTH:0]   STEP_W = (GAIN_WIDTH + 1)'(RAMP_STEP);
    localparam logic [GAIN_WIDTH-1:0] STEP_G = GAIN_WIDTH'(RAMP_STEP);
    localparam logic signed [PW-1:0]  MAX_V  = {{(PW - DATA_WIDTH + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
    localparam logic signed [PW-1:0]  MIN_V  = {{(PW - DATA_WIDTH + 1){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};
    localparam logic [DATA_WIDTH-1:0] MAX_D  = {1'b0, {(DATA_WIDTH - 1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] MIN_D  = {1'b1, {(DATA_WIDTH - 1){1'b0}}};

    logic [GAIN_WIDTH-1:0] gain_q;
    logic [GAIN_WIDTH-1:0] target;
    logic [GAIN_WIDTH-1:0] gain_ramp;
    logic [GAIN_WIDTH-1:0] gain_next;
    logic [GAIN_WIDTH:0]   up_sum;
    logic [GAIN_WIDTH:0]   down_diff;

    logic signed [PW-1:0]  prod_l_q;
    logic signed [PW-1:0]  prod_r_q;
    logic                  s1_valid_q;

    logic [DATA_WIDTH:0]   sat_l;
    logic [DATA_WIDTH:0]   sat_r;

    // Slew toward the target; the widened sum/difference keeps the clamp free of wraparound.
    always_comb begin
        target    = i_mute ? '0 : i_gain;
        up_sum    = {1'b0, gain_q} + STEP_W;
        down_diff = {1'b0, gain_q} - {1'b0, target};
        gain_ramp = gain_q;
        if (gain_q < target) begin
            gain_ramp = (up_sum >= {1'b0, target}) ? target : up_sum[GAIN_WIDTH-1:0];
        end else if (gain_q > target) begin
            gain_ramp = (down_diff <= STEP_W) ? target : gain_q - STEP_G;
        end
        gain_next = RAMP_EN ? gain_ramp : target;
    end

    // Stage 1: products use the gain held this cycle; the gain register updates on the same edge.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            gain_q     <= '0;
            prod_l_q   <= '0;
            prod_r_q   <= '0;
            s1_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= i_data_valid;
            if (i_data_valid) begin
                prod_l_q <= PW'($signed(i_data_left))  * PW'($signed({1'b0, gain_q}));
                prod_r_q <= PW'($signed(i_data_right)) * PW'($signed({1'b0, gain_q}));
                gain_q   <= gain_next;
            end
        end
    end

    // Returns {clip, value}; >>> on a signed operand floors toward minus infinity.
    function automatic logic [DATA_WIDTH:0] shift_sat(input logic signed [PW-1:0] prod);
        logic signed [PW-1:0] shifted;
        shifted = prod >>> (GAIN_WIDTH - 1);
        if (shifted > MAX_V) begin
            return {1'b1, MAX_D};
        end else if (shifted < MIN_V) begin
            return {1'b1, MIN_D};
        end
        return {1'b0, shifted[DATA_WIDTH-1:0]};
    endfunction

    always_comb begin
        sat_l = shift_sat(prod_l_q);
        sat_r = shift_sat(prod_r_q);
    end

    // Stage 2: data holds between pulses, clip only ever accompanies a valid pulse.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            o_data_left  <= '0;
            o_data_right <= '0;
            o_data_valid <= 1'b0;
            o_clip       <= 1'b0;
        end else begin
            o_data_valid <= s1_valid_q;
            if (s1_valid_q) begin
                o_data_left  <= sat_l[DATA_WIDTH-1:0];
                o_data_right <= sat_r[DATA_WIDTH-1:0];
                o_clip       <= sat_l[DATA_WIDTH] | sat_r[DATA_WIDTH];
            end else begin
                o_clip       <= 1'b0;
            end
        end
    end

    assign o_gain_current = gain_q;

endmodule

// File: tb/tb_monitor_gain_controller.sv
// Bench for monitor_gain_controller: arithmetic reference model with per-cycle compare plus directed literal checks.
module tb_monitor_gain_controller;

  localparam int DW    = 24;
  localparam int GW    = 8;
  localparam int STEP  = 1;
  localparam int UNITY = 1 << (GW - 1);
  localparam int EW    = 32 + 1 + DW + DW;

  logic          i_clock = 1'b0;
  logic          i_reset;
  logic [DW-1:0] i_data_left;
  logic [DW-1:0] i_data_right;
  logic          i_data_valid;
  logic [GW-1:0] i_gain;
  logic          i_mute;
  logic [DW-1:0] o_data_left;
  logic [DW-1:0] o_data_right;
  logic          o_data_valid;
  logic          o_clip;
  logic [GW-1:0] o_gain_current;

  monitor_gain_controller #(
    .DATA_WIDTH(DW),
    .GAIN_WIDTH(GW),
    .RAMP_STEP (STEP)
  ) dut (
    .i_clock       (i_clock),
    .i_reset       (i_reset),
    .i_data_left   (i_data_left),
    .i_data_right  (i_data_right),
    .i_data_valid  (i_data_valid),
    .i_gain        (i_gain),
    .i_mute        (i_mute),
    .o_data_left   (o_data_left),
    .o_data_right  (o_data_right),
    .o_data_valid  (o_data_valid),
    .o_clip        (o_clip),
    .o_gain_current(o_gain_current)
  );

  // clock / reset
  always #5 i_clock = ~i_clock;

  int checks = 0;
  int passes = 0;
  int cyc    = 0;
  int g_m    = 0;
  bit cmp_en = 1'b0;
  logic [EW-1:0] exp_q[$];
  logic [DW-1:0] last_l = '0;
  logic [DW-1:0] last_r = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, cyc);
  endtask

  // reference model
  function automatic logic [DW:0] model_scale(input logic [DW-1:0] s, input int g);
    longint p, q, maxv, minv;
    maxv = (longint'(1) << (DW - 1)) - 1;
    minv = -(longint'(1) << (DW - 1));
    p = longint'($signed(s)) * longint'(g);
    q = p / UNITY;
    if (p < 0 && (p % UNITY) != 0) q = q - 1;
    if (q > maxv) return {1'b1, maxv[DW-1:0]};
    if (q < minv) return {1'b1, minv[DW-1:0]};
    return {1'b0, q[DW-1:0]};
  endfunction

  function automatic int model_gain(input int g, input int t);
`ifdef MONITOR_GAIN_RAMP_EN
    if (g < t) return (g + STEP > t) ? t : g + STEP;
    if (g > t) return (g - STEP < t) ? t : g - STEP;
    return g;
`else
    return t + 0 * g;
`endif
  endfunction

  always @(posedge i_clock) begin : model_blk
    logic [DW:0] rl;
    logic [DW:0] rr;
    cyc++;
    if (i_reset) begin
      g_m = 0;
      exp_q.delete();
      last_l = '0;
      last_r = '0;
    end else if (i_data_valid) begin
      rl = model_scale(i_data_left, g_m);
      rr = model_scale(i_data_right, g_m);
      exp_q.push_back({32'(cyc + 1), rl[DW] | rr[DW], rl[DW-1:0], rr[DW-1:0]});
      g_m = model_gain(g_m, i_mute ? 0 : int'(i_gain));
    end
  end

  // scoreboard compare, away from the active edge
  always @(negedge i_clock) begin : cmp_blk
    logic [EW-1:0] e;
    logic [31:0]   due;
    if (cmp_en) begin
      e   = '0;
      due = '0;
      if (exp_q.size() > 0) begin
        e   = exp_q[0];
        due = e[EW-1 -: 32];
      end
      if (exp_q.size() > 0 && due == 32'(cyc)) begin
        e = exp_q.pop_front();
        check("sb_valid", o_data_valid, 1);
        check("sb_left",  o_data_left,  e[2*DW-1:DW]);
        check("sb_right", o_data_right, e[DW-1:0]);
        check("sb_clip",  o_clip,       e[2*DW]);
        last_l = e[2*DW-1:DW];
        last_r = e[DW-1:0];
      end else begin
        check("sb_idle_valid", o_data_valid, 0);
        check("sb_idle_clip",  o_clip,       0);
        check("sb_hold_left",  o_data_left,  last_l);
        check("sb_hold_right", o_data_right, last_r);
      end
      check("sb_gain", o_gain_current, g_m);
    end
  end

  // driver tasks
  task automatic step(input bit v, input logic [DW-1:0] l, input logic [DW-1:0] r,
                      input int gain, input bit mute, input bit rst);
    i_data_valid = v;
    i_data_left  = l;
    i_data_right = r;
    i_gain       = GW'(gain);
    i_mute       = mute;
    i_reset      = rst;
    @(posedge i_clock);
    #1;
  endtask

  task automatic idle(input int gain);
    step(1'b0, '0, '0, gain, 1'b0, 1'b0);
  endtask

  task automatic settle(input int t);
    for (int n = 0; n < 600 && g_m != t; n++) step(1'b1, '0, '0, t, 1'b0, 1'b0);
    check("settle_gain", o_gain_current, t);
  endtask

  initial begin : stim
    int exp_g[5];
`ifdef MONITOR_GAIN_RAMP_EN
    exp_g = '{1, 2, 3, 4, 4};
`else
    exp_g = '{4, 4, 4, 4, 4};
`endif

    step(1'b0, '0, '0, 0, 1'b0, 1'b1);
    step(1'b1, 24'h111111, 24'h222222, 200, 1'b0, 1'b1);
    cmp_en = 1'b1;
    check("reset_valid", o_data_valid, 0);
    check("reset_left",  o_data_left,  0);
    check("reset_right", o_data_right, 0);
    check("reset_clip",  o_clip,       0);
    check("reset_gain",  o_gain_current, 0);

    // gain from zero toward 4, first pair must come out as zero
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 24'h001000, 24'h001000, 4, 1'b0, 1'b0);
      check("ramp_gain", o_gain_current, exp_g[i]);
      if (i == 1) begin
        check("ramp_first_valid", o_data_valid, 1);
        check("ramp_first_left",  o_data_left,  0);
      end
    end
    idle(4);
    idle(4);

    // unity
    settle(128);
    step(1'b1, 24'h123456, 24'hFEDCBA, 128, 1'b0, 1'b0);
    idle(128);
    check("unity_valid", o_data_valid, 1);
    check("unity_left",  o_data_left,  24'h123456);
    check("unity_right", o_data_right, 24'hFEDCBA);
    check("unity_clip",  o_clip,       0);

    // half gain, floor on negatives
    settle(64);
    step(1'b1, 24'h000100, 24'hFFFFFD, 64, 1'b0, 1'b0);
    idle(64);
    check("half_left",  o_data_left,  24'h000080);
    check("half_right", o_data_right, 24'hFFFFFE);
    check("half_clip",  o_clip,       0);

    // saturation both rails
    settle(255);
    step(1'b1, 24'h7FFFFF, 24'h800000, 255, 1'b0, 1'b0);
    idle(255);
    check("sat_left",  o_data_left,  24'h7FFFFF);
    check("sat_right", o_data_right, 24'h800000);
    check("sat_clip",  o_clip,       1);
    idle(255);
    check("sat_clip_drop", o_clip, 0);
    check("sat_hold_left", o_data_left, 24'h7FFFFF);

    // back-to-back pairs while the target keeps moving
    step(1'b1, 24'h7FFFFF, 24'h000001, 200, 1'b0, 1'b0);
    step(1'b1, 24'h800000, 24'hFFFFFF, 10,  1'b0, 1'b0);
    step(1'b1, 24'h3FFFFF, 24'hC00000, 255, 1'b0, 1'b0);
    step(1'b0, 24'hABCDEF, 24'hABCDEF, 0,   1'b0, 1'b0);
    step(1'b1, 24'h400000, 24'hBFFFFF, 0,   1'b0, 1'b0);
    step(1'b1, 24'h0F0F0F, 24'hF0F0F0, 128, 1'b1, 1'b0);
    step(1'b1, 24'h000081, 24'hFFFF7F, 77,  1'b0, 1'b0);
    idle(77);
    idle(77);

    // mute
    settle(128);
`ifdef MONITOR_GAIN_RAMP_EN
    for (int i = 0; i < 128; i++) step(1'b1, 24'h010000, 24'h010000, 128, 1'b1, 1'b0);
    check("mute_gain_zero", o_gain_current, 0);
    step(1'b1, 24'h010000, 24'h010000, 128, 1'b1, 1'b0);
    idle(128);
    check("mute_out_zero", o_data_left, 0);
`else
    step(1'b1, 24'h010000, 24'h010000, 128, 1'b1, 1'b0);
    step(1'b1, 24'h010000, 24'h010000, 128, 1'b1, 1'b0);
    check("mute_gain_zero", o_gain_current, 0);
    check("mute_first_out", o_data_left, 24'h010000);
    idle(128);
    check("mute_second_out", o_data_left, 0);
`endif
    idle(128);

    // reset mid-stream drops in-flight pairs
    settle(128);
    step(1'b1, 24'h333333, 24'h333333, 128, 1'b0, 1'b0);
    step(1'b1, 24'h111111, 24'h111111, 128, 1'b0, 1'b0);
    step(1'b1, 24'h222222, 24'h222222, 128, 1'b0, 1'b1);
    check("rst_mid_valid0", o_data_valid, 0);
    check("rst_mid_left",   o_data_left,  0);
    check("rst_mid_right",  o_data_right, 0);
    check("rst_mid_gain",   o_gain_current, 0);
    idle(128);
    check("rst_mid_valid1", o_data_valid, 0);
    check("rst_mid_clip",   o_clip, 0);

    // recovery after reset
    settle(100);
    step(1'b1, 24'h000200, 24'hFFFE00, 100, 1'b0, 1'b0);
    idle(100);
    check("recover_left",  o_data_left,  24'h000190);
    check("recover_right", o_data_right, 24'hFFFE70);
    idle(100);
    idle(100);

    if (exp_q.size() != 0) check("sb_drain", exp_q.size(), 0);
    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
